// File: rtl/stream_width_upconv_if.sv
// stream_width_upconv_if: narrow input stream, wide output stream and fill level of the width up-converter
interface stream_width_upconv_if #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
);
  logic [IN_WIDTH-1:0]         in0_V_V_TDATA;
  logic                        in0_V_V_TVALID;
  logic                        in0_V_V_TREADY;
  logic [IN_WIDTH*RATIO-1:0]   out_V_V_TDATA;
  logic                        out_V_V_TVALID;
  logic                        out_V_V_TREADY;
  logic [$clog2(RATIO+1)-1:0]  fill;
  modport slave (
    input  in0_V_V_TDATA, in0_V_V_TVALID, out_V_V_TREADY,
    output in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, fill
  );
  modport master (
    output in0_V_V_TDATA, in0_V_V_TVALID, out_V_V_TREADY,
    input  in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, fill
  );
endinterface

// File: rtl/stream_width_upconv.sv
// stream_width_upconv: packs RATIO input words into one output word, first-received word in the LSBs
module stream_width_upconv #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input logic               ap_clk,
  input logic               ap_rst,
  stream_width_upconv_if.slave bus
);
  localparam int FW = $clog2(RATIO+1);
  localparam int AW = IN_WIDTH*(RATIO-1);
  localparam logic [FW-1:0] LAST = FW'(RATIO-1);
  logic [FW-1:0] idx;
  logic [AW-1:0] acc;
  logic          last;
  logic          in_xfer;
  assign last = idx == LAST;
  // only the completing word needs the output register, so earlier words flow under back-pressure
  assign bus.in0_V_V_TREADY = !last || !bus.out_V_V_TVALID || bus.out_V_V_TREADY;
  assign in_xfer = bus.in0_V_V_TVALID && bus.in0_V_V_TREADY;
  assign bus.fill = idx;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      idx                <= '0;
      acc                <= '0;
      bus.out_V_V_TVALID <= 1'b0;
      bus.out_V_V_TDATA  <= '0;
    end else begin
      if (bus.out_V_V_TVALID && bus.out_V_V_TREADY) bus.out_V_V_TVALID <= 1'b0;
      if (in_xfer && last) begin
        bus.out_V_V_TDATA  <= {bus.in0_V_V_TDATA, acc};
        bus.out_V_V_TVALID <= 1'b1;
        idx                <= '0;
      end else if (in_xfer) begin
        acc[int'(idx)*IN_WIDTH +: IN_WIDTH] <= bus.in0_V_V_TDATA;
        idx                                 <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stream_width_upconv.sv
// tb_stream_width_upconv: directed vectors plus a throttled random run against a packing scoreboard
module tb_stream_width_upconv;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  stream_width_upconv_if #(.IN_WIDTH(8), .RATIO(4)) b ();
  stream_width_upconv_if #(.IN_WIDTH(8), .RATIO(2)) c ();

  stream_width_upconv #(.IN_WIDTH(8), .RATIO(4)) dut (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(b.slave));
  stream_width_upconv #(.IN_WIDTH(8), .RATIO(2)) dut2 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(c.slave));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    b.in0_V_V_TDATA  = d;
    b.in0_V_V_TVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (b.in0_V_V_TREADY) begin
        tick();
        b.in0_V_V_TVALID = 1'b0;
        return;
      end
      tick();
    end
    check("send_timeout", b.in0_V_V_TREADY, 1);
    b.in0_V_V_TVALID = 1'b0;
  endtask

  logic [31:0] words [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [7:0]  q_in [$];
  logic [31:0] q_exp [$];

  initial begin
    int sent, got, cyc;
    logic pv, pr;
    logic [31:0] pd;
    b.in0_V_V_TDATA = '0; b.in0_V_V_TVALID = 1'b0; b.out_V_V_TREADY = 1'b1;
    c.in0_V_V_TDATA = '0; c.in0_V_V_TVALID = 1'b0; c.out_V_V_TREADY = 1'b1;
    tick(); tick();
    check("rst_fill", b.fill, 0);
    check("rst_valid", b.out_V_V_TVALID, 0);
    check("rst_data", b.out_V_V_TDATA, 0);
    check("rst_ready", b.in0_V_V_TREADY, 1);
    ap_rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      check("basic_fill", b.fill, i);
      send(8'(8'h11 * (i + 1)));
    end
    check("basic_valid", b.out_V_V_TVALID, 1);
    check("basic_data", b.out_V_V_TDATA, 32'h44332211);
    check("basic_fill_wrap", b.fill, 0);
    tick();
    check("basic_drain", b.out_V_V_TVALID, 0);

    for (int i = 0; i < 16; i++) begin
      b.in0_V_V_TDATA = 8'(i);
      b.in0_V_V_TVALID = 1'b1;
      #1;
      check("cont_ready", b.in0_V_V_TREADY, 1);
      tick();
      check("cont_valid", b.out_V_V_TVALID, (i % 4) == 3);
      if ((i % 4) == 3) check("cont_data", b.out_V_V_TDATA, words[i/4]);
    end
    b.in0_V_V_TVALID = 1'b0;
    tick();

    b.out_V_V_TREADY = 1'b0;
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    check("bp_pending", b.out_V_V_TDATA, 32'hDDCCBBAA);
    send(8'h01); send(8'h02); send(8'h03);
    check("bp_fill", b.fill, 3);
    check("bp_hold_data", b.out_V_V_TDATA, 32'hDDCCBBAA);
    b.in0_V_V_TDATA = 8'h04;
    b.in0_V_V_TVALID = 1'b1;
    #1;
    check("bp_stall_ready", b.in0_V_V_TREADY, 0);
    tick();
    check("bp_stall_fill", b.fill, 3);
    check("bp_stall_valid", b.out_V_V_TVALID, 1);
    check("bp_stall_data", b.out_V_V_TDATA, 32'hDDCCBBAA);
    b.out_V_V_TREADY = 1'b1;
    #1;
    check("bp_release_ready", b.in0_V_V_TREADY, 1);
    tick();
    b.in0_V_V_TVALID = 1'b0;
    check("bp_next_valid", b.out_V_V_TVALID, 1);
    check("bp_next_data", b.out_V_V_TDATA, 32'h04030201);
    check("bp_next_fill", b.fill, 0);
    tick();
    check("bp_drain", b.out_V_V_TVALID, 0);

    send(8'h55); send(8'h66);
    check("mid_fill", b.fill, 2);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check("mid_rst_fill", b.fill, 0);
    check("mid_rst_valid", b.out_V_V_TVALID, 0);
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    check("mid_after_data", b.out_V_V_TDATA, 32'hA3A2A1A0);
    tick();

    sent = 0; got = 0; cyc = 0; pv = 1'b0; pr = 1'b1; pd = '0;
    while (got < 1024 && cyc < 60000) begin
      b.in0_V_V_TVALID = (sent < 4096) && 1'($urandom_range(0, 1));
      b.in0_V_V_TDATA  = 8'($urandom);
      b.out_V_V_TREADY = 1'($urandom_range(0, 1));
      #1;
      if (pv && !pr) begin
        check("rand_hold_valid", b.out_V_V_TVALID, 1);
        check("rand_hold_data", b.out_V_V_TDATA, pd);
      end
      if (b.in0_V_V_TVALID && b.in0_V_V_TREADY) begin
        q_in.push_back(b.in0_V_V_TDATA);
        sent++;
        if (q_in.size() == 4) begin
          q_exp.push_back({q_in[3], q_in[2], q_in[1], q_in[0]});
          q_in.delete();
        end
      end
      if (b.out_V_V_TVALID && b.out_V_V_TREADY) begin
        check("rand_word", b.out_V_V_TDATA, q_exp.size() != 0 ? {32'h0, q_exp.pop_front()} : 'x);
        got++;
      end
      pv = b.out_V_V_TVALID; pr = b.out_V_V_TREADY; pd = b.out_V_V_TDATA;
      tick();
      cyc++;
    end
    check("rand_count", got, 1024);
    check("rand_sent", sent, 4096);
    b.in0_V_V_TVALID = 1'b0;

    check("r2_fill0", c.fill, 0);
    c.in0_V_V_TDATA = 8'hAB; c.in0_V_V_TVALID = 1'b1;
    tick();
    check("r2_fill1", c.fill, 1);
    check("r2_idle", c.out_V_V_TVALID, 0);
    c.in0_V_V_TDATA = 8'hCD;
    tick();
    c.in0_V_V_TVALID = 1'b0;
    check("r2_valid", c.out_V_V_TVALID, 1);
    check("r2_data", c.out_V_V_TDATA, 16'hCDAB);
    check("r2_fill_wrap", c.fill, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_width_upconv.md
STREAM_WIDTH_UPCONV -- requirements
Module: stream_width_upconv

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: input stream word width in bits.
REQ-002 SHALL have parameter RATIO, default 4: input words packed per output word; legal range 2..64.
REQ-003 SHALL derive OUT_WIDTH = IN_WIDTH*RATIO (default 32); OUT_WIDTH is not settable independently.
REQ-004 ap_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 ap_rst  input  1  reset, synchronous, active-high.
REQ-006 in0_V_V_TDATA  input  IN_WIDTH  input word, from the upstream StreamingFIFO out_V_V port.
REQ-007 in0_V_V_TVALID  input  1  input word valid.
REQ-008 in0_V_V_TREADY  output  1  block accepts the input word this cycle.
REQ-009 out_V_V_TDATA  output  OUT_WIDTH  packed output word.
REQ-010 out_V_V_TVALID  output  1  output word valid.
REQ-011 out_V_V_TREADY  input  1  downstream accepts the output word.
REQ-012 fill  output  clog2(RATIO+1)  count of input words currently held in the accumulator (0..RATIO-1).

Function
REQ-013 Input transfer SHALL occur when in0_V_V_TVALID and in0_V_V_TREADY are both 1 on a rising edge; output transfer likewise with out_V_V_TVALID and out_V_V_TREADY.
REQ-014 Accumulator SHALL hold RATIO-1 slots plus an index idx (0..RATIO-1); fill SHALL equal idx.
REQ-015 On an input transfer with idx < RATIO-1: word SHALL be stored in slot idx, idx SHALL increment; no output change.
REQ-016 On an input transfer with idx = RATIO-1: output register SHALL load {in0 word, slot RATIO-2, ..., slot 0}, out_V_V_TVALID SHALL be 1 next cycle, idx SHALL return to 0.
REQ-017 Packing order: first-received input word SHALL occupy out_V_V_TDATA[IN_WIDTH-1:0]; k-th word (0-based) occupies bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
REQ-018 in0_V_V_TREADY SHALL be 1 when idx < RATIO-1, or out_V_V_TVALID = 0, or out_V_V_TREADY = 1; otherwise 0. It SHALL be independent of in0_V_V_TVALID.
REQ-019 Simultaneous output transfer and completing input transfer SHALL load the new word and keep out_V_V_TVALID = 1 (sustained 1 output per RATIO inputs, no bubble).
REQ-020 Output transfer without a completing input SHALL clear out_V_V_TVALID next cycle.
REQ-021 While out_V_V_TVALID = 1 and out_V_V_TREADY = 0, out_V_V_TDATA SHALL remain stable and out_V_V_TVALID SHALL remain 1.
REQ-022 Latency: the completing input word SHALL appear on out_V_V_TDATA exactly one cycle after its transfer edge.
REQ-023 in0_V_V_TDATA SHALL be ignored when no input transfer occurs; out_V_V_TDATA value is don't-care while out_V_V_TVALID = 0.
REQ-024 No combinational path SHALL exist from in0_V_V_TVALID or in0_V_V_TDATA to any output; the only combinational path SHALL be out_V_V_TREADY to in0_V_V_TREADY.
REQ-025 Block SHALL not drop, duplicate or reorder input words under any valid/ready pattern.

Reset
REQ-026 With ap_rst = 1 at a rising edge: idx = 0, fill = 0, out_V_V_TVALID = 0, accumulator contents discarded; in0_V_V_TREADY SHALL read 1 in the following cycle.
REQ-027 Reset mid-packet SHALL discard partially accumulated words and any pending output word; no transfer SHALL be reported during a reset cycle.
REQ-028 out_V_V_TDATA SHALL reset to 0.

Verification
REQ-029 Bench: defaults, ready held 1, input 0x11,0x22,0x33,0x44 on consecutive cycles -> out 0x44332211 valid one cycle after 0x44, fill 0,1,2,3,0.
REQ-030 Bench: continuous input 0x00..0x0F, ready held 1 -> 4 outputs 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, in0 TREADY constantly 1.
REQ-031 Bench: output 0xDDCCBBAA pending, out TREADY = 0, feed 0x01,0x02,0x03,0x04 -> first three accepted (fill=3), TREADY low for 0x04, out data stable; raise out TREADY -> 0x04 accepted same cycle, next output 0x04030201.
REQ-032 Bench: assert ap_rst after 0x55,0x66 accepted (fill=2) -> fill=0, out TVALID=0; then feed 0xA0..0xA3 -> out 0xA3A2A1A0 with no 0x55/0x66 content.
REQ-033 Bench: random valid/ready throttling (50%), 4096 random bytes -> scoreboard matches 1024 words packed LSB-first, TDATA stable under back-pressure.
REQ-034 Bench: IN_WIDTH=8, RATIO=2, input 0xAB,0xCD -> out 0xCDAB; fill toggles 0,1,0.
